reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Reset controller that stages the release of reset across `N_DOM` downstream register domains, such as banks of resettable flip-flops. A single asynchronous active-high reset asserts every domain reset at once. Release is synchronized to `i_clk`, and domains then leave reset one at a time, in index order, with a programmable gap between them. The block sits at the top of each clock region and also provides a software-initiated re-reset with busy and done status.

## Interface
- `N_DOM`, 4: number of domain resets; legal range 1..16.
- `SYNC_STAGES`, 2: depth of the reset-release synchronizer; minimum 2.
- `CNT_W`, 8: width of the hold/gap counter and of `i_hold_cycles`.

Ports:
- `i_clk`, in, 1: single clock.
- `i_rst`, in, 1: reset, asynchronous, active-high.
- `i_sw_req`, in, 1: software reset request; sampled only in IDLE.
- `i_hold_cycles`, in, `CNT_W`: gap H between successive releases; value 0 is treated as 1.
- `o_rst_dom`, out, `N_DOM`: active-high domain resets, one bit per domain.
- `o_busy`, out, 1: high while the sequence is in progress (state != IDLE).
- `o_done`, out, 1: one-cycle pulse when the last domain is released.
- `o_state`, out, 2: current FSM state, for debug.

## Operation
- State encoding: IDLE=00, SYNC=01, HOLD=10, REL=11.
- Reset values while `i_rst` is high: `o_rst_dom` all ones, state SYNC, `o_busy`=1, `o_done`=0, counter and domain index 0, synchronizer chain all ones.
- `i_rst` assertion is asynchronous. It forces all outputs to their reset values immediately, without waiting for a clock edge.
- `i_rst` deassertion passes through a `SYNC_STAGES`-deep chain of flops, each asynchronously set by `i_rst`. Only the chain output is used by the FSM.
- **SYNC**
  - Holds all domain resets asserted.
  - When the chain output reads 0: latch H = max(`i_hold_cycles`, 1), clear the counter, and go to HOLD.
- **HOLD / REL**
  - The counter increments every cycle.
  - When the counter equals H-1: clear the counter, deassert `o_rst_dom[idx]`, and increment idx.
  - Go from HOLD to REL after the first release.
  - When idx reaches `N_DOM`-1 and that domain is released: go to IDLE and pulse `o_done` in the same cycle.
- **IDLE**
  - All domain resets are released.
  - If `i_sw_req`=1 at an edge: assert all `o_rst_dom` bits at that edge, latch H from `i_hold_cycles`, clear the counter and idx, and go to HOLD.
- Release order is fixed: domain 0 first, then ascending index. A domain's reset, once released, stays low until the next `i_rst` or software request.
- `i_sw_req` outside IDLE is ignored and is not queued.
- `i_hold_cycles` is sampled only when entering HOLD. Changes during a sequence have no effect.
- `i_rst` reasserted mid-sequence aborts the sequence immediately: all domains reassert, the FSM returns to SYNC, and no `o_done` pulse is produced.
- All outputs are registered except `o_busy` and `o_state`, which decode directly from the state register.

## Timing
- Let E1 be the first rising edge with `i_rst` low. The chain output reads 0 after edge E(`SYNC_STAGES`).
- The FSM leaves SYNC at edge Eh = E(`SYNC_STAGES`+1).
- Domain k releases at edge Eh + H·(k+1).
- `o_done` is high for the single cycle following edge Eh + H·`N_DOM`. `o_busy` falls at that same edge.
- For a software request sampled at edge Es, Eh = Es, and the same release formula applies.
- From `i_rst` falling to full release takes `SYNC_STAGES` + 1 + H·`N_DOM` edges.
  - Defaults with H=3: 15 edges.
- Maximum gap H is 2^`CNT_W`-1. The counter never wraps within a sequence.

## Test plan
- **Power-on release:** defaults, H=3, `i_rst` falls before E1. Required: `o_rst_dom` = 1111 through E5, then 1110 at E6, 1100 at E9, 1000 at E12, 0000 at E15. `o_done` is high for exactly one cycle after E15, and `o_state` ends at 00.
- **Zero gap:** H=0. Required: treated as 1, so domains release at E4, E5, E6, E7, and `o_done` pulses after E7.
- **Software re-reset:** in IDLE, `i_sw_req` pulsed at edge Es with H=2. Required: all ones after Es, domain k releases at Es+2(k+1), and `o_busy` is high from Es to Es+8.
- **Request while busy plus mid-sequence gap change:** `i_sw_req` pulsed during REL, and `i_hold_cycles` changed 3→7 mid-sequence. Required: the request is ignored, gaps stay 3, and exactly one `o_done` pulse occurs.
- **Async abort:** `i_rst` asserted between edges while state is REL and `o_rst_dom`=1100. Required: all ones immediately with no clock edge, `o_state`=01, no `o_done`. After `i_rst` falls, the full sequence restarts from SYNC with the original timing.
- **Single domain:** `N_DOM`=1, `SYNC_STAGES`=3, H=5. Required: the release falls at E9, and `o_done` pulses after E9.

Source files
------------

// File: rtl/reset_sequencer.sv
// reset_sequencer: staged, in-order release of N_DOM domain resets with a programmable gap and software re-reset
module reset_sequencer #(
  parameter int N_DOM       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_sw_req,
  input  logic [CNT_W-1:0] i_hold_cycles,
  output logic [N_DOM-1:0] o_rst_dom,
  output logic             o_busy,
  output logic             o_done,
  output logic [1:0]       o_state
);
  localparam int IW = N_DOM > 1 ? $clog2(N_DOM) : 1;
  typedef enum logic [1:0] {IDLE = 2'b00, SYNC = 2'b01, HOLD = 2'b10, REL = 2'b11} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, hm1_q, hm1_d, hold_m1;
  logic [IW-1:0] idx_q, idx_d;
  logic [N_DOM-1:0] rst_dom_q, rst_dom_d;
  logic done_q, done_d, start, tick, last;
  // gap is stored as H-1 so a zero request behaves as a gap of one cycle
  assign hold_m1 = i_hold_cycles - CNT_W'(i_hold_cycles != '0);
  assign start = state_q == SYNC ? !sync_q[SYNC_STAGES-1] : (state_q == IDLE && i_sw_req);
  assign tick = cnt_q == hm1_q;
  assign last = idx_q == IW'(N_DOM - 1);
  // next-state: start a sequence, or count the gap and release domains in ascending order
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    hm1_d = hm1_q;
    idx_d = idx_q;
    rst_dom_d = rst_dom_q;
    done_d = 1'b0;
    if (state_q == SYNC || state_q == IDLE) begin
      if (start) begin
        state_d = HOLD;
        hm1_d = hold_m1;
        cnt_d = '0;
        idx_d = '0;
        rst_dom_d = '1;
      end
    end else if (tick) begin
      cnt_d = '0;
      rst_dom_d = rst_dom_q << 1;
      idx_d = idx_q + IW'(1);
      state_d = last ? IDLE : REL;
      done_d = last;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end
  // release synchronizer: each stage is set asynchronously and shifts in zeros after reset drops
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
  end
  // sequencer state and registered outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= SYNC;
      cnt_q <= '0;
      hm1_q <= '0;
      idx_q <= '0;
      rst_dom_q <= '1;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      hm1_q <= hm1_d;
      idx_q <= idx_d;
      rst_dom_q <= rst_dom_d;
      done_q <= done_d;
    end
  end
  assign o_rst_dom = rst_dom_q;
  assign o_done = done_q;
  assign o_busy = state_q != IDLE;
  assign o_state = state_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed checks of release timing, software re-reset, abort and single-domain build
module tb_reset_sequencer;
  logic clk = 1'b0, rst = 1'b1, sw_req = 1'b0, rst2 = 1'b1, sw2 = 1'b0;
  logic [7:0] hold = 8'd3, hold2 = 8'd5;
  logic [3:0] dom;
  logic [0:0] dom2;
  logic busy, done, busy2, done2;
  logic [1:0] state, state2;
  int n_chk = 0, n_fail = 0, dones;

  reset_sequencer dut (
    .i_clk(clk), .i_rst(rst), .i_sw_req(sw_req), .i_hold_cycles(hold),
    .o_rst_dom(dom), .o_busy(busy), .o_done(done), .o_state(state)
  );

  reset_sequencer #(.N_DOM(1), .SYNC_STAGES(3), .CNT_W(8)) dut1 (
    .i_clk(clk), .i_rst(rst2), .i_sw_req(sw2), .i_hold_cycles(hold2),
    .o_rst_dom(dom2), .o_busy(busy2), .o_done(done2), .o_state(state2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // steps ne edges; edge e=1 is the first edge of the window, eh is the edge leaving SYNC/IDLE
  task automatic run(input string tag, input int inst, input int n, input int eh, input int h,
                     input int ne, input int mid, output int nd);
    int fin;
    logic [3:0] expd;
    logic [1:0] exps;
    nd = 0;
    fin = eh + h * n;
    for (int e = 1; e <= ne; e++) begin
      @(posedge clk);
      #1;
      sw_req = 1'b0;
      if (e == mid) begin
        sw_req = 1'b1;
        hold = 8'd7;
      end
      expd = '0;
      for (int k = 0; k < n; k++) expd[k] = e < eh + h * (k + 1);
      exps = e < eh ? 2'b01 : e >= fin ? 2'b00 : e < eh + h ? 2'b10 : 2'b11;
      chk($sformatf("%s e%0d dom", tag, e), inst ? {31'd0, dom2} : {28'd0, dom}, {28'd0, expd});
      chk($sformatf("%s e%0d state", tag, e), inst ? {30'd0, state2} : {30'd0, state}, {30'd0, exps});
      chk($sformatf("%s e%0d busy", tag, e), inst ? busy2 : busy, e < fin);
      chk($sformatf("%s e%0d done", tag, e), inst ? done2 : done, e == fin);
      nd += inst ? int'(done2) : int'(done);
    end
  endtask

  initial begin
    #12;
    chk("reset dom", dom, 4'b1111);
    chk("reset state", state, 2'b01);
    chk("reset busy", busy, 1'b1);
    chk("reset done", done, 1'b0);
    chk("reset dom1", dom2, 1'b1);
    rst = 1'b0;
    run("poweron", 0, 4, 3, 3, 17, 0, dones);
    chk("poweron dones", dones, 1);

    #2 rst = 1'b1;
    #1;
    chk("async dom", dom, 4'b1111);
    chk("async state", state, 2'b01);
    hold = 8'd0;
    @(posedge clk);
    #1 rst = 1'b0;
    run("zerogap", 0, 4, 3, 1, 9, 0, dones);
    chk("zerogap dones", dones, 1);

    hold = 8'd2;
    sw_req = 1'b1;
    run("swreq", 0, 4, 1, 2, 10, 0, dones);
    chk("swreq dones", dones, 1);

    hold = 8'd3;
    sw_req = 1'b1;
    run("busyreq", 0, 4, 1, 3, 16, 5, dones);
    chk("busyreq dones", dones, 1);

    hold = 8'd3;
    sw_req = 1'b1;
    run("preabort", 0, 4, 1, 3, 8, 0, dones);
    #3 rst = 1'b1;
    #1;
    chk("abort dom", dom, 4'b1111);
    chk("abort state", state, 2'b01);
    chk("abort busy", busy, 1'b1);
    chk("abort done", done, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("abort hold%0d dom", i), dom, 4'b1111);
      chk($sformatf("abort hold%0d done", i), done, 1'b0);
    end
    rst = 1'b0;
    run("restart", 0, 4, 3, 3, 17, 0, dones);
    chk("restart dones", dones, 1);

    rst2 = 1'b0;
    run("single", 1, 1, 4, 5, 11, 0, dones);
    chk("single dones", dones, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
